// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: holds HI/LO and keeps busy high for a
// fixed number of cycles per operation, publishing the result only on completion.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  cnt;
   logic [31:0] hi_n;
   logic [31:0] lo_n;
   logic        div_zero;

   logic        issue;
   logic        is_div;
   logic        mul_signed;
   logic        div_signed;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] product;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] divisor_safe;
   logic [31:0] uquot;
   logic [31:0] urem;
   logic [31:0] quot;
   logic [31:0] rem;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   assign issue  = (state == IDLE) && start &&
                   (md_op == OP_MULT || md_op == OP_MULTU ||
                    md_op == OP_DIV  || md_op == OP_DIVU);
   assign is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);

   // Signed division runs on magnitudes and fixes signs afterwards, which also
   // makes 0x80000000 / -1 come out as 0x80000000 without overflow.
   always_comb begin
      mul_signed   = (md_op == OP_MULT);
      div_signed   = (md_op == OP_DIV);
      mul_a        = {{32{mul_signed & a[31]}}, a};
      mul_b        = {{32{mul_signed & b[31]}}, b};
      product      = mul_a * mul_b;
      a_neg        = div_signed & a[31];
      b_neg        = div_signed & b[31];
      dividend     = a_neg ? (~a + 32'd1) : a;
      divisor      = b_neg ? (~b + 32'd1) : b;
      divisor_safe = (divisor == 32'd0) ? 32'd1 : divisor;
      uquot        = dividend / divisor_safe;
      urem         = dividend % divisor_safe;
      quot         = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
      rem          = a_neg ? (~urem + 32'd1) : urem;
      if (is_div) begin
         res_hi = rem;
         res_lo = quot;
      end else begin
         res_hi = product[63:32];
         res_lo = product[31:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (issue) state_next = RUN;
         RUN:     if (cnt == 4'd0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
   end

   // HI/LO only change from mthi/mtlo while idle or from a completed,
   // non-divide-by-zero operation; everything arriving during RUN is ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= 4'd0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         hi_n     <= 32'd0;
         lo_n     <= 32'd0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  hi_n     <= res_hi;
                  lo_n     <= res_lo;
                  cnt      <= is_div ? DIV_LOAD : MULT_LOAD;
                  div_zero <= is_div && (b == 32'd0);
               end else if (md_op == OP_MTHI) begin
                  hi <= a;
               end else if (md_op == OP_MTLO) begin
                  lo <= a;
               end
            end
            RUN: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (!div_zero) begin
                  hi <= hi_n;
                  lo <= lo_n;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the five-stage pipelined MIPS core. Sits in the E stage beside the ALU and executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`. It drives the `start`/`busy` pair that the stall/forward unit consumes to hold `mfhi`, `mflo`, `mthi`, `mtlo` and new multiply/divide instructions in D. It holds the architectural HI/LO registers and exposes them to the E-stage result mux.

## Interface
- `MULT_CYCLES`, default 5: busy length of `mult`/`multu`, in cycles.
- `DIV_CYCLES`, default 10: busy length of `div`/`divu`, in cycles.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle issue strobe; high while a mult/div instruction is in E.
- `md_op`  in  3  operation select:
  - 0 none
  - 1 mult
  - 2 multu
  - 3 div
  - 4 divu
  - 5 mthi
  - 6 mtlo
  - 7 reserved, treated as none
- `a`  in  32  rs operand, already forwarded.
- `b`  in  32  rt operand, already forwarded.
- `busy`  out  1  operation in progress.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; cycle counter `cnt`, 4 bits, counts down.
- IDLE to RUN requires `start`=1 and `md_op` in 1..4 at a rising edge. At that edge:
  - latch the result into shadow registers `hi_n`/`lo_n`;
  - load `cnt` with MULT_CYCLES-1 or DIV_CYCLES-1;
  - set the division-by-zero flag if the op is div/divu and `b`=0.
- In RUN, `cnt` decrements each edge. At the edge where `cnt`=0:
  - copy `hi_n`/`lo_n` into `hi`/`lo`, unless the division-by-zero flag is set;
  - return to IDLE.
- Arithmetic:
  - `mult`: 64-bit signed product; HI = [63:32], LO = [31:0].
  - `multu`: same, unsigned.
  - `div`: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. Example: -7/2 gives LO=-3, HI=-1.
  - `div` 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - `divu`: unsigned quotient and remainder.
  - Divisor 0: HI/LO unchanged. Busy still lasts the full DIV_CYCLES.
- `mthi`/`mtlo` when IDLE (`start` is don't-care): HI or LO <= `a` at the next edge. `busy` stays 0.
- Ignored inputs, with no state change (these cases are protocol violations because the stall unit prevents them):
  - `start` or `mthi`/`mtlo` while in RUN;
  - `start` with `md_op` outside 1..4.
- `hi`/`lo` keep their old values for the whole of RUN. Results appear only after completion.

## Timing
- Reset (asynchronous, immediate): `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0, shadow registers and flag cleared. Any in-flight operation is discarded.
- Reset released mid-cycle: the first operation is accepted at the first rising edge where `reset`=0.
- Let edge E0 be the edge that samples `start`=1.
  - `busy` is 1 after E0 and stays 1 through edge E0+N-1.
  - At edge E0+N, `busy` falls and `hi`/`lo` update in the same edge.
  - N = MULT_CYCLES or DIV_CYCLES, so `busy` is high for exactly N cycles.
- Back-to-back issue: `start` may be 1 on the cycle right after `busy` falls. It is accepted at that edge and `busy` rises again.
- `busy`, `hi` and `lo` are registered outputs. No combinational path runs from inputs to outputs.
- `mthi`/`mtlo` latency is one edge. A following `mfhi` in E reads the new value on the next cycle.

## Test plan
- mult, a=0xFFFFFFFD, b=5, `start` pulse at E0:
  - `busy`=1 for exactly 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFF1;
  - hi/lo hold their old values while busy.
- multu, a=0xFFFFFFFF, b=2: hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div sign cases, each with 10 busy cycles:
  - a=0xFFFFFFF9, b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0;
  - divu, a=7, b=0: hi/lo unchanged, `busy` still high for 10 cycles.
- mthi/mtlo:
  - mthi a=0x12345678 when idle: hi=0x12345678 after one edge, `busy` stays 0;
  - mtlo issued during a mult RUN: ignored, and lo ends at the mult result.
- Back-to-back mult then div, with the second `start` on the cycle `busy` falls: `busy` is low for 1 cycle, then 10 cycles high, and both results are correct in order.
- `reset` asserted in the 4th cycle of a div (asynchronous, between edges): `busy`, hi and lo go to 0 immediately. After release, no late result is written.
